fxp_div_seq: RTL and testbench
==============================

Name: fxp_div_seq

Overview:
- Sequential signed fixed-point divider: the inverse operation of the team's fixed-point multipliers in the regression datapath.
- Computes quotient = num / den, with operands and result all in the datapath's signed Q(WIDTH-FRAC).FRAC format (default Q6.8, 14 bits).
- Non-restoring-free radix-2 restoring algorithm, one quotient bit per clock, start/done handshake.
- Used by the regression solver for slope/normalisation terms (e.g. Sxy/Sxx).

Parameters:
WIDTH, 14, total bits of num, den and quotient (two's complement)
FRAC, 8, fractional bits shared by all three operands

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
num  input  WIDTH  signed dividend, captured on the accepted start edge
den  input  WIDTH  signed divisor, captured on the accepted start edge
busy  output  1  high from the accepted start edge until done
done  output  1  one-cycle pulse when quotient is valid
quotient  output  WIDTH  signed result, held until next accepted start
ovf  output  1  result saturated due to range overflow; valid with done, held
dbz  output  1  den was zero; valid with done, held

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quotient=0, ovf=0, dbz=0; any in-flight division aborts, nothing is reported.
- States and transitions:
  - IDLE -> CALC on start=1. Capture sign=num[MSB]^den[MSB], |num|, |den| (WIDTH-bit unsigned; |-2^(WIDTH-1)| is representable), dividend={|num|,FRAC zeros}, remainder=0, iter=0. busy=1.
  - CALC: N iterations, N=WIDTH+FRAC (22 default). Each cycle: rem={rem,next dividend bit}; if rem>=|den| then rem-=|den| and qbit=1, else qbit=0. Shift qbit into the N-bit unsigned q. Go to FIX after iter=N-1.
  - FIX (1 cycle): dbz = (den==0). Limit = 2^(WIDTH-1)-1 if sign=0, else 2^(WIDTH-1).
    - dbz: quotient = num>=0 ? max positive : min negative; ovf=0.
    - q>limit: saturate to max positive / min negative; ovf=1.
    - otherwise: quotient = sign ? -q : q; ovf=0.
    - Go to DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: done asserts N+2 rising edges after the edge that accepted start (24 default), independent of operand values, including the dbz case.
- Next start is accepted in the cycle after DONE (IDLE). Back-to-back throughput = N+3 cycles.
- start while busy=1 (including the DONE cycle) is ignored; num/den changes after capture have no effect.
- quotient/ovf/dbz update only in FIX and are held otherwise. They are not cleared by a new start.
- Rounding without the feature: truncation toward zero (magnitude truncated, then sign applied).
- num=0 with den!=0 -> quotient=0, flags 0.

Optional Feature:
Macro FXP_DIV_ROUND_EN.
- Defined: one extra iteration (N=WIDTH+FRAC+1) produces a guard bit. Final magnitude = (q>>1)+guard, i.e. round half away from zero, applied before the saturation check. Latency becomes N+2 = 25.
- Undefined: truncation toward zero, N=WIDTH+FRAC, latency 24.

Test Plan:
- Reset mid-op: num=768, den=512, start; pull rst_n low at cycle 10 -> outputs all 0 immediately, no done pulse; later start with the same operands -> done at edge 24, quotient=384 (1.5).
- Signs: num=-768, den=512 -> quotient=-384. num=768, den=-512 -> -384. num=-768, den=-512 -> 384. ovf=dbz=0 for all three.
- Fraction/rounding: num=512, den=768 -> 170 without the macro, 171 with FXP_DIV_ROUND_EN. num=256, den=768 -> 85 in both builds.
- Overflow: num=8191, den=1 -> quotient=8191, ovf=1. num=-8192, den=-256 -> 8191, ovf=1. num=-8192, den=256 -> -8192, ovf=0.
- Divide by zero: num=-256, den=0 -> quotient=-8192, dbz=1. num=0, den=0 -> 8191, dbz=1. Both with done at edge 24.
- Handshake: hold start high continuously with changing operands -> only the first is captured; done pulses exactly one cycle; the next capture happens on the IDLE cycle after DONE, giving a 25-cycle period.

Source files
------------

// File: rtl/fxp_div_seq.sv
// rtl/fxp_div_seq.sv - sequential signed fixed-point divider, one quotient bit per clock
// Optional round-half-away-from-zero via FXP_DIV_ROUND_EN (adds one guard iteration).
module fxp_div_seq #(
    parameter int WIDTH = 14,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             ovf,
    output logic             dbz
);

`ifdef FXP_DIV_ROUND_EN
    localparam int N = WIDTH + FRAC + 1;
`else
    localparam int N = WIDTH + FRAC;
`endif
    localparam int IW = $clog2(N);
    localparam int DZ = N - WIDTH;

    localparam logic [N-1:0]     LIM_POS = {{(DZ+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [N-1:0]     LIM_NEG = {{DZ{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_iter;
    logic [N-1:0]     r_dvd;
    logic [N-1:0]     r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic             r_sign;
    logic             r_num_neg;
    logic             r_den_zero;
    logic [WIDTH-1:0] r_quotient;
    logic             r_ovf;
    logic             r_dbz;

    logic [WIDTH-1:0] w_abs_num;
    logic [WIDTH-1:0] w_abs_den;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [N-1:0]     w_mag;
    logic [N-1:0]     w_limit;
    logic [WIDTH-1:0] w_mag_lo;
    logic             w_accept;

    // Magnitudes stay unsigned WIDTH bits so |-2^(WIDTH-1)| is representable.
    assign w_abs_num = num[WIDTH-1] ? (~num + WIDTH'(1)) : num;
    assign w_abs_den = den[WIDTH-1] ? (~den + WIDTH'(1)) : den;
    assign w_accept  = (r_state == S_IDLE) && start;

    assign w_rem_sh  = {r_rem, r_dvd[N-1]};
    assign w_ge      = w_rem_sh >= {1'b0, r_den};
    assign w_rem_nxt = w_ge ? (w_rem_sh[WIDTH-1:0] - r_den) : w_rem_sh[WIDTH-1:0];

`ifdef FXP_DIV_ROUND_EN
    assign w_mag = {1'b0, r_q[N-1:1]} + {{(N-1){1'b0}}, r_q[0]};
`else
    assign w_mag = r_q;
`endif
    assign w_limit  = r_sign ? LIM_NEG : LIM_POS;
    assign w_mag_lo = w_mag[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_iter == IW'(N - 1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter     <= '0;
            r_dvd      <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_den      <= '0;
            r_sign     <= 1'b0;
            r_num_neg  <= 1'b0;
            r_den_zero <= 1'b0;
            r_quotient <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iter     <= '0;
                r_dvd      <= {w_abs_num, {DZ{1'b0}}};
                r_q        <= '0;
                r_rem      <= '0;
                r_den      <= w_abs_den;
                r_sign     <= num[WIDTH-1] ^ den[WIDTH-1];
                r_num_neg  <= num[WIDTH-1];
                r_den_zero <= (den == '0);
            end else if (r_state == S_CALC) begin
                r_iter <= r_iter + IW'(1);
                r_dvd  <= {r_dvd[N-2:0], 1'b0};
                r_rem  <= w_rem_nxt;
                r_q    <= {r_q[N-2:0], w_ge};
            end else if (r_state == S_FIX) begin
                // Divide-by-zero takes priority; its quotient is a don't-care run of ones.
                if (r_den_zero) begin
                    r_quotient <= r_num_neg ? Q_MIN : Q_MAX;
                    r_ovf      <= 1'b0;
                    r_dbz      <= 1'b1;
                end else if (w_mag > w_limit) begin
                    r_quotient <= r_sign ? Q_MIN : Q_MAX;
                    r_ovf      <= 1'b1;
                    r_dbz      <= 1'b0;
                end else begin
                    r_quotient <= r_sign ? (~w_mag_lo + WIDTH'(1)) : w_mag_lo;
                    r_ovf      <= 1'b0;
                    r_dbz      <= 1'b0;
                end
            end
        end
    end

    assign quotient = r_quotient;
    assign ovf      = r_ovf;
    assign dbz      = r_dbz;

endmodule

// File: tb/tb_fxp_div_seq.sv
// tb/tb_fxp_div_seq.sv - self-checking bench for fxp_div_seq against an arithmetic reference
module tb_fxp_div_seq;

    localparam int W = 14;
    localparam int F = 8;
`ifdef FXP_DIV_ROUND_EN
    localparam int N = W + F + 1;
    localparam int Q_2_3 = 171;
`else
    localparam int N = W + F;
    localparam int Q_2_3 = 170;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic         ovf;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    fxp_div_seq #(.WIDTH(W), .FRAC(F)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num      (num),
        .den      (den),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int n, input int d, output int q, output int o, output int z);
        int an, ad, mag, lim;
        bit neg;
        o = 0;
        z = 0;
        if (d == 0) begin
            z = 1;
            q = (n >= 0) ? 8191 : -8192;
        end else begin
            an  = (n < 0) ? -n : n;
            ad  = (d < 0) ? -d : d;
            neg = (n < 0) != (d < 0);
`ifdef FXP_DIV_ROUND_EN
            mag = ((an * (1 << (F + 1))) / ad + 1) / 2;
`else
            mag = (an * (1 << F)) / ad;
`endif
            lim = neg ? 8192 : 8191;
            if (mag > lim) begin
                o = 1;
                q = neg ? -8192 : 8191;
            end else begin
                q = neg ? -mag : mag;
            end
        end
    endfunction

    function automatic int rnd_op();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    task automatic run_div(input int n, input int d, input int qe, input int oe, input int ze, input string tag);
        int lat;
        @(negedge clk);
        num   = n[W-1:0];
        den   = d[W-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        num   = W'($urandom);
        den   = W'($urandom);
        lat   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, ".busy"}, int'(busy), 1);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, lat, N + 2);
        chk({tag, ".quotient"}, int'($signed(quotient)), qe);
        chk({tag, ".ovf"}, int'(ovf), oe);
        chk({tag, ".dbz"}, int'(dbz), ze);
        @(negedge clk);
        chk({tag, ".done_width"}, int'(done), 0);
    endtask

    initial begin
        int q, o, z, n, d, seen, d1, d2, ncap, prev_dn;
        int capn [3];
        int capd [3];
        logic b, dn;

        rst_n = 1'b0;
        start = 1'b0;
        num   = '0;
        den   = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.quotient", int'(quotient), 0);
        chk("reset.ovf", int'(ovf), 0);
        chk("reset.dbz", int'(dbz), 0);
        rst_n = 1'b1;

        run_div(768, 512, 384, 0, 0, "pre_reset");

        @(negedge clk);
        num   = 14'd768;
        den   = 14'd512;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.quotient", int'(quotient), 0);
        chk("midrst.ovf", int'(ovf), 0);
        chk("midrst.dbz", int'(dbz), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst.no_done", seen, 0);
        run_div(768, 512, 384, 0, 0, "after_reset");

        run_div(-768, 512, -384, 0, 0, "sign_nn");
        run_div(768, -512, -384, 0, 0, "sign_nd");
        run_div(-768, -512, 384, 0, 0, "sign_both");
        run_div(512, 768, Q_2_3, 0, 0, "frac_2_3");
        run_div(256, 768, 85, 0, 0, "frac_1_3");
        run_div(8191, 1, 8191, 1, 0, "ovf_pos");
        run_div(-8192, -256, 8191, 1, 0, "ovf_negneg");
        run_div(-8192, 256, -8192, 0, 0, "min_exact");
        run_div(-256, 0, -8192, 0, 1, "dbz_neg");
        run_div(0, 0, 8191, 0, 1, "dbz_zero");
        run_div(0, 300, 0, 0, 0, "zero_num");

        for (int i = 0; i < 30; i++) begin
            n = rnd_op();
            d = (i % 3 == 0) ? int'($urandom_range(0, 600)) - 300 : rnd_op();
            model(n, d, q, o, z);
            run_div(n, d, q, o, z, $sformatf("rnd%0d", i));
        end

        // Start held high: each capture happens in the single IDLE cycle after DONE.
        d1 = -1;
        d2 = -1;
        ncap = 0;
        prev_dn = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            b  = busy;
            dn = done;
            if (prev_dn != 0) chk("hs.done_width", int'(dn), 0);
            if (dn) begin
                model(capn[(d1 < 0) ? 0 : 1], capd[(d1 < 0) ? 0 : 1], q, o, z);
                chk((d1 < 0) ? "hs.q1" : "hs.q2", int'($signed(quotient)), q);
                if (d1 < 0) begin
                    d1 = c;
                end else begin
                    d2 = c;
                    break;
                end
            end
            prev_dn = int'(dn);
            n     = rnd_op();
            d     = rnd_op();
            num   = n[W-1:0];
            den   = d[W-1:0];
            start = 1'b1;
            if (!b && !dn && ncap < 3) begin
                capn[ncap] = n;
                capd[ncap] = d;
                ncap++;
            end
        end
        start = 1'b0;
        chk("hs.first_latency", d1, N + 2);
        chk("hs.period", d2 - d1, N + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
